text_overlay: RTL

//  Parametrised successor to the fixed "GAME OVER" renderer: draws a NUM_CHARS-long string of 8x16 glyphs
//  at (MSG_X,MSG_Y), integer-scaled by SCALE, with a runtime-writable message buffer.

---
 rtl/text_overlay.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/text_overlay.sv
// text_overlay: renders a NUM_CHARS-long string of 8x16 glyphs at (MSG_X,MSG_Y),
// integer-scaled by 2**SCALE_LOG2. The message buffer can be rewritten at run time.
// A per-frame fade-in / blink state machine sets the foreground blend level.
// Output RGB is registered two cycles after the pixel coordinate is presented.
module text_overlay #(
    parameter int          MSG_X        = 200,
    parameter int          MSG_Y        = 150,
    parameter int          NUM_CHARS    = 9,
    parameter int          SCALE_LOG2   = 0,
    parameter int          FADE_STEP    = 32,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] FG_RGB       = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB       = 24'h000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       frame_tick,
    input  logic       show,
    input  logic       blink_en,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [3:0] wr_code,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue
);

    localparam int BOX_W = (NUM_CHARS * 8) << SCALE_LOG2;
    localparam int BOX_H = 16 << SCALE_LOG2;
    localparam int CW    = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {ST_OFF, ST_FADE, ST_ON, ST_DARK} state_t;

    // Glyph bitmaps: row r in bits [r*8 +: 8], bit c = column c (LSB is the leftmost column).
    function automatic logic [127:0] glyph_rom(input logic [3:0] code);
        case (code)
            4'd1: glyph_rom = {56'h0, 8'h7C, 8'h66, 8'h63, 8'h73, 8'h03, 8'h03, 8'h03, 8'h66, 8'h3C}; // G
            4'd2: glyph_rom = {56'h0, 8'h66, 8'h66, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h3C, 8'h18}; // A
            4'd3: glyph_rom = {56'h0, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h6B, 8'h7F, 8'h77, 8'h63}; // M
            4'd4: glyph_rom = {56'h0, 8'h7F, 8'h03, 8'h03, 8'h03, 8'h3F, 8'h03, 8'h03, 8'h03, 8'h7F}; // E
            4'd5: glyph_rom = {56'h0, 8'h3E, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63, 8'h3E}; // O
            4'd6: glyph_rom = {56'h0, 8'h08, 8'h1C, 8'h36, 8'h36, 8'h63, 8'h63, 8'h63, 8'h63, 8'h63}; // V
            4'd7: glyph_rom = {56'h0, 8'h63, 8'h63, 8'h33, 8'h1B, 8'h3F, 8'h63, 8'h63, 8'h63, 8'h3F}; // R
            default: glyph_rom = 128'h0;                                                           // space/blank
        endcase
    endfunction

    // Power-up message "GAME OVER"; slots beyond it start as spaces.
    function automatic logic [3:0] init_code(input int slot);
        case (slot)
            0: init_code = 4'd1;
            1: init_code = 4'd2;
            2: init_code = 4'd3;
            3: init_code = 4'd4;
            5: init_code = 4'd5;
            6: init_code = 4'd6;
            7: init_code = 4'd4;
            8: init_code = 4'd7;
            default: init_code = 4'd0;
        endcase
    endfunction

    // Buffer is always 32 deep so the 5-bit character index never leaves the array.
    logic [3:0]    r_buf [32];
    logic          r_in;
    logic [2:0]    r_col;
    logic [3:0]    r_row;
    logic [3:0]    r_code;
    logic [23:0]   r_rgb;
    state_t        r_state, w_state_next;
    logic [8:0]    r_level, w_level_next;
    logic [CW-1:0] r_cnt, w_cnt_next;

    logic [10:0]   w_x11, w_y11, w_dx, w_dy;
    logic          w_in_box;
    logic [4:0]    w_char;
    logic [9:0]    w_level_sum;
    logic [8:0]    w_level_eff;
    logic [127:0]  w_glyph;
    logic          w_bit;
    logic [23:0]   w_lit_rgb;
    logic          w_unused_bits;

    // Coordinates are widened to 11 bits so the box edges never wrap.
    assign w_x11    = {1'b0, pixel_x};
    assign w_y11    = {1'b0, pixel_y};
    assign w_in_box = (w_x11 >= 11'(MSG_X)) && (w_x11 < 11'(MSG_X + BOX_W)) &&
                      (w_y11 >= 11'(MSG_Y)) && (w_y11 < 11'(MSG_Y + BOX_H));
    assign w_dx     = (w_x11 - 11'(MSG_X)) >> SCALE_LOG2;
    assign w_dy     = (w_y11 - 11'(MSG_Y)) >> SCALE_LOG2;
    assign w_char   = w_dx[7:3];
    assign w_unused_bits = ^{w_dx[10:8], w_dy[10:4]};

    // Message buffer: reset loads the default text; writes to slots past the message are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_buf[i] <= init_code(i);
        end else if (wr_en && (32'(wr_addr) < NUM_CHARS)) begin
            r_buf[wr_addr] <= wr_code;
        end
    end

    // Stage 1: box flag, glyph column/row and the character code (old value on a same-cycle write).
    always_ff @(posedge clock) begin
        if (reset) begin
            r_in   <= 1'b0;
            r_col  <= 3'd0;
            r_row  <= 4'd0;
            r_code <= 4'd0;
        end else begin
            r_in   <= w_in_box;
            r_col  <= w_dx[2:0];
            r_row  <= w_dy[3:0];
            r_code <= r_buf[w_char];
        end
    end

    // Fade/blink state register, stepped by frame_tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_OFF;
            r_level <= 9'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_level <= w_level_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_level_sum = {1'b0, r_level} + 10'(FADE_STEP);

    // Next state: show=0 forces OFF; fade ramps to 256; blink alternates ON/DARK every BLINK_FRAMES ticks.
    always_comb begin
        w_state_next = r_state;
        w_level_next = r_level;
        w_cnt_next   = r_cnt;
        if (!show) begin
            w_state_next = ST_OFF;
            w_level_next = 9'd0;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_next = ST_FADE;
                    w_level_next = 9'd0;
                    w_cnt_next   = '0;
                end
                ST_FADE: begin
                    if (frame_tick) begin
                        if (w_level_sum >= 10'd256) begin
                            w_level_next = 9'd256;
                            w_state_next = ST_ON;
                        end else begin
                            w_level_next = w_level_sum[8:0];
                        end
                    end
                end
                ST_ON: begin
                    if (!blink_en) begin
                        w_cnt_next = '0;
                    end else if (frame_tick) begin
                        if (r_cnt == BLINK_LAST) begin
                            w_state_next = ST_DARK;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
                end
                ST_DARK: begin
                    if (!blink_en) begin
                        w_state_next = ST_ON;
                        w_cnt_next   = '0;
                    end else if (frame_tick) begin
                        if (r_cnt == BLINK_LAST) begin
                            w_state_next = ST_ON;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    w_state_next = ST_OFF;
                    w_level_next = 9'd0;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    // DARK keeps the fade level but draws at level 0.
    assign w_level_eff = (r_state == ST_DARK) ? 9'd0 : r_level;
    assign w_glyph     = glyph_rom(r_code);
    assign w_bit       = w_glyph[{r_row, r_col}];

    // Per-channel blend BG + ((FG-BG)*level >>> 8); channel 0 is blue, 2 is red.
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        localparam logic [7:0] FG_CH = FG_RGB[gi*8 +: 8];
        localparam logic [7:0] BG_CH = BG_RGB[gi*8 +: 8];
        localparam logic signed [9:0] DIFF = $signed({2'b00, FG_CH}) - $signed({2'b00, BG_CH});
        logic signed [19:0] w_prod;
        assign w_prod = 20'(DIFF) * 20'($signed({1'b0, w_level_eff}));
        assign w_lit_rgb[gi*8 +: 8] = BG_CH + 8'(w_prod >>> 8);
    end

    // Stage 2: registered colour; outside the box or an unset glyph bit shows background.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rgb <= 24'h0;
        end else begin
            r_rgb <= (r_in && w_bit) ? w_lit_rgb : BG_RGB;
        end
    end

    assign red   = r_rgb[23:16];
    assign green = r_rgb[15:8];
    assign blue  = r_rgb[7:0];

endmodule
